car_parking_ctrl: RTL and testbench

CAR_PARKING_CTRL -- requirements
Module: car_parking_ctrl

---
 rtl/car_parking_pkg.sv | 20 ++
 rtl/parking_timer.sv | 35 +++
 rtl/car_parking_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_car_parking_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/car_parking_pkg.sv
// Shared types and default constants for the car park entry controller.
package car_parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PASS,
        RIGHT_PASS,
        WRONG_PASS,
        STOP,
        LOCKOUT
    } park_state_e;

    localparam int              DEF_CAPACITY    = 8;
    localparam int              DEF_PW_W        = 4;
    localparam logic [3:0]      DEF_PASSWORD    = 4'b1011;
    localparam int              DEF_MAX_TRIES   = 3;
    localparam int              DEF_WAIT_CYCLES = 100;
    localparam int              DEF_LOCK_CYCLES = 200;

endpackage

// File: rtl/parking_timer.sv
// Loadable down-counter shared by the password timeout and the lockout hold-off.
module parking_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         enable_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over counting; the count parks at zero once it gets there.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/car_parking_ctrl.sv
// Car park entry controller: password-gated barrier, tailgate stop, lockout and occupancy count.
module car_parking_ctrl
    import car_parking_pkg::*;
#(
    parameter int              CAPACITY    = DEF_CAPACITY,
    parameter int              PW_W        = DEF_PW_W,
    parameter logic [PW_W-1:0] PASSWORD    = PW_W'(DEF_PASSWORD),
    parameter int              MAX_TRIES   = DEF_MAX_TRIES,
    parameter int              WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int              LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sensor_entrace,
    input  logic                          sensor_exit,
    input  logic                          car_leave,
    input  logic [PW_W-1:0]               password,
    input  logic                          password_vld,
    output logic                          led_wait,
    output logic                          led_available,
    output logic                          led_alert,
    output logic                          gate_open,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy,
    output logic                          full
);

    localparam int OCC_W   = $clog2(CAPACITY + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [OCC_W-1:0] CAP_VAL   = OCC_W'(CAPACITY);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
    // Loaded with N-1 so the state lasts exactly N cycles before the expire edge.
    localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(WAIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);

    park_state_e      state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d, triesInc;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             exitPrev_q;
    logic             ledWait_q, ledWait_d;
    logic             ledAvail_q, ledAvail_d;
    logic             ledAlert_q, ledAlert_d;
    logic             gate_q, gate_d;
    logic             full_q, full_d;

    logic             pwMatch, pwMiss, exitRise;
    logic             inc, capDrop, idleAlert;
    logic             timerLoad, timerExpire;
    logic [TMR_W-1:0] timerVal;

    assign pwMatch  = password_vld && (password == PASSWORD);
    assign pwMiss   = password_vld && (password != PASSWORD);
    assign exitRise = sensor_exit && !exitPrev_q;
    assign triesInc = tries_q + TRY_W'(1);

    // Next-state logic; the timer is reloaded on every state change and on each retry.
    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        inc       = 1'b0;
        idleAlert = 1'b0;
        timerLoad = 1'b0;
        case (state_q)
            IDLE: begin
                if (sensor_entrace) begin
                    if (!full_q) begin
                        state_d = WAIT_PASS;
                    end else begin
                        idleAlert = 1'b1;
                    end
                end
            end
            WAIT_PASS, WRONG_PASS: begin
                if (pwMatch) begin
                    state_d = RIGHT_PASS;
                    tries_d = '0;
                end else if (pwMiss) begin
                    timerLoad = 1'b1;
                    tries_d   = triesInc;
                    state_d   = (triesInc == TRY_LIMIT) ? LOCKOUT : WRONG_PASS;
                end else if (timerExpire) begin
                    state_d = IDLE;
                    tries_d = '0;
                end
            end
            RIGHT_PASS: begin
                if (sensor_exit && sensor_entrace) begin
                    inc     = 1'b1;
                    state_d = STOP;
                end else if (exitRise && !sensor_entrace) begin
                    inc     = 1'b1;
                    state_d = IDLE;
                end
            end
            STOP: begin
                if (full_q && !sensor_entrace) begin
                    state_d = IDLE;
                end else if (pwMatch) begin
                    state_d = RIGHT_PASS;
                end
            end
            LOCKOUT: begin
                if (timerExpire) begin
                    state_d = IDLE;
                    tries_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                tries_d = '0;
            end
        endcase
        if (state_d != state_q) begin
            timerLoad = 1'b1;
        end
        timerVal = (state_d == LOCKOUT) ? LOCK_LOAD : WAIT_LOAD;
    end

    // A simultaneous entry and departure cancel out; an entry into a full lot is dropped.
    always_comb begin
        occ_d   = occ_q;
        capDrop = 1'b0;
        if (inc && !car_leave) begin
            if (occ_q == CAP_VAL) begin
                capDrop = 1'b1;
            end else begin
                occ_d = occ_q + OCC_W'(1);
            end
        end else if (!inc && car_leave && (occ_q != '0)) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Indicators are decoded from the next state so they line up with the state register.
    always_comb begin
        ledWait_d  = (state_d == WAIT_PASS) || (state_d == WRONG_PASS);
        ledAvail_d = (state_d == RIGHT_PASS);
        gate_d     = (state_d == RIGHT_PASS);
        ledAlert_d = (state_d == WRONG_PASS) || (state_d == STOP) || (state_d == LOCKOUT)
                     || idleAlert || capDrop;
        full_d     = (occ_d == CAP_VAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tries_q    <= '0;
            occ_q      <= '0;
            exitPrev_q <= 1'b0;
            ledWait_q  <= 1'b0;
            ledAvail_q <= 1'b0;
            ledAlert_q <= 1'b0;
            gate_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            occ_q      <= occ_d;
            exitPrev_q <= sensor_exit;
            ledWait_q  <= ledWait_d;
            ledAvail_q <= ledAvail_d;
            ledAlert_q <= ledAlert_d;
            gate_q     <= gate_d;
            full_q     <= full_d;
        end
    end

    parking_timer #(
        .W (TMR_W)
    ) uTimer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timerLoad),
        .load_val_i (timerVal),
        .enable_i   (1'b1),
        .expire_o   (timerExpire)
    );

    assign led_wait      = ledWait_q;
    assign led_available = ledAvail_q;
    assign led_alert     = ledAlert_q;
    assign gate_open     = gate_q;
    assign occupancy     = occ_q;
    assign full          = full_q;

endmodule

// File: tb/tb_car_parking_ctrl.sv
// Directed vector bench for car_parking_ctrl with default parameters.
module tb_car_parking_ctrl;

    logic       clk;
    logic       rst;
    logic       sensor_entrace;
    logic       sensor_exit;
    logic       car_leave;
    logic [3:0] password;
    logic       password_vld;
    logic       led_wait;
    logic       led_available;
    logic       led_alert;
    logic       gate_open;
    logic [3:0] occupancy;
    logic       full;

    int testsRun;
    int testsFailed;

    localparam logic [3:0] PW_OK  = 4'b1011;
    localparam logic [3:0] PW_BAD = 4'b0000;

    typedef struct {
        string      name;
        logic       rst;
        logic       ent;
        logic       ex;
        logic       leave;
        logic [3:0] pw;
        logic       vld;
        logic       eWait;
        logic       eAvail;
        logic       eAlert;
        logic       eGate;
        logic [3:0] eOcc;
        logic       eFull;
    } vec_t;

    vec_t vecs[$];

    car_parking_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .sensor_entrace (sensor_entrace),
        .sensor_exit    (sensor_exit),
        .car_leave      (car_leave),
        .password       (password),
        .password_vld   (password_vld),
        .led_wait       (led_wait),
        .led_available  (led_available),
        .led_alert      (led_alert),
        .gate_open      (gate_open),
        .occupancy      (occupancy),
        .full           (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic x, input logic l,
                                 input logic [3:0] p, input logic v);
        @(negedge clk);
        rst            = r;
        sensor_entrace = e;
        sensor_exit    = x;
        car_leave      = l;
        password       = p;
        password_vld   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eW, input logic eAv, input logic eAl,
                               input logic eG, input logic [3:0] eO, input logic eF);
        testsRun++;
        if ({led_wait, led_available, led_alert, gate_open, occupancy, full} !==
            {eW, eAv, eAl, eG, eO, eF}) begin
            testsFailed++;
            $display("[TB] FAIL %s: got wait=%b avail=%b alert=%b gate=%b occ=%0d full=%b, expected wait=%b avail=%b alert=%b gate=%b occ=%0d full=%b",
                     name, led_wait, led_available, led_alert, gate_open, occupancy, full,
                     eW, eAv, eAl, eG, eO, eF);
        end
    endtask

    task automatic checkCount(input string name, input int bad);
        testsRun++;
        if (bad != 0) begin
            testsFailed++;
            $display("[TB] FAIL %s: %0d cycles off, expected 0", name, bad);
        end
    endtask

    task automatic addVec(input string n, input logic r, input logic e, input logic x, input logic l,
                          input logic [3:0] p, input logic v, input logic eW, input logic eAv,
                          input logic eAl, input logic eG, input logic [3:0] eO, input logic eF);
        vec_t t;
        t.name = n; t.rst = r; t.ent = e; t.ex = x; t.leave = l; t.pw = p; t.vld = v;
        t.eWait = eW; t.eAvail = eAv; t.eAlert = eAl; t.eGate = eG; t.eOcc = eO; t.eFull = eF;
        vecs.push_back(t);
    endtask

    task automatic parkCar();
        applyStimulus(0, 1, 0, 0, PW_BAD, 0);
        applyStimulus(0, 1, 0, 0, PW_OK, 1);
        applyStimulus(0, 0, 1, 0, PW_BAD, 0);
        applyStimulus(0, 0, 0, 0, PW_BAD, 0);
    endtask

    initial begin
        int bad;
        testsRun       = 0;
        testsFailed    = 0;
        rst            = 1'b1;
        sensor_entrace = 1'b0;
        sensor_exit    = 1'b0;
        car_leave      = 1'b0;
        password       = '0;
        password_vld   = 1'b0;

        //     name           rst ent ex lv pw      vld  W Av Al G occ F
        addVec("rst0",          1, 0, 0, 0, PW_BAD, 0,   0, 0, 0, 0, 0, 0);
        addVec("rst1",          1, 0, 0, 0, PW_BAD, 0,   0, 0, 0, 0, 0, 0);
        addVec("enterWait",     0, 1, 0, 0, PW_BAD, 0,   1, 0, 0, 0, 0, 0);
        addVec("holdWait",      0, 1, 0, 0, PW_BAD, 0,   1, 0, 0, 0, 0, 0);
        addVec("rightPass",     0, 1, 0, 0, PW_OK,  1,   0, 1, 0, 1, 0, 0);
        addVec("holdRight",     0, 0, 0, 0, PW_BAD, 0,   0, 1, 0, 1, 0, 0);
        addVec("exitCar",       0, 0, 1, 0, PW_BAD, 0,   0, 0, 0, 0, 1, 0);
        addVec("idle1",         0, 0, 0, 0, PW_BAD, 0,   0, 0, 0, 0, 1, 0);
        addVec("leave",         0, 0, 0, 1, PW_BAD, 0,   0, 0, 0, 0, 0, 0);
        addVec("leaveSat",      0, 0, 0, 1, PW_BAD, 0,   0, 0, 0, 0, 0, 0);
        addVec("vldIdle",       0, 0, 0, 0, PW_OK,  1,   0, 0, 0, 0, 0, 0);
        addVec("enterWait2",    0, 1, 0, 0, PW_BAD, 0,   1, 0, 0, 0, 0, 0);
        addVec("right2",        0, 1, 0, 0, PW_OK,  1,   0, 1, 0, 1, 0, 0);
        addVec("tailgate",      0, 1, 1, 0, PW_BAD, 0,   0, 0, 1, 0, 1, 0);
        addVec("stopWrong",     0, 1, 1, 0, PW_BAD, 1,   0, 0, 1, 0, 1, 0);
        addVec("stopRight",     0, 1, 1, 0, PW_OK,  1,   0, 1, 0, 1, 1, 0);
        addVec("holdRight2",    0, 0, 0, 0, PW_BAD, 0,   0, 1, 0, 1, 1, 0);
        addVec("exitCar2",      0, 0, 1, 0, PW_BAD, 0,   0, 0, 0, 0, 2, 0);
        addVec("idle2",         0, 0, 0, 0, PW_BAD, 0,   0, 0, 0, 0, 2, 0);
        addVec("enterWait3",    0, 1, 0, 0, PW_BAD, 0,   1, 0, 0, 0, 2, 0);
        addVec("right3",        0, 1, 0, 0, PW_OK,  1,   0, 1, 0, 1, 2, 0);
        addVec("rstRight",      1, 1, 0, 0, PW_BAD, 0,   0, 0, 0, 0, 0, 0);
        addVec("afterRst",      0, 0, 0, 0, PW_BAD, 0,   0, 0, 0, 0, 0, 0);
        addVec("enterWait4",    0, 1, 0, 0, PW_BAD, 0,   1, 0, 0, 0, 0, 0);
        addVec("right4",        0, 0, 0, 0, PW_OK,  1,   0, 1, 0, 1, 0, 0);
        addVec("incLeave",      0, 0, 1, 1, PW_BAD, 0,   0, 0, 0, 0, 0, 0);
        addVec("idle4",         0, 0, 0, 0, PW_BAD, 0,   0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].ent, vecs[i].ex, vecs[i].leave, vecs[i].pw, vecs[i].vld);
            checkOutput(vecs[i].name, vecs[i].eWait, vecs[i].eAvail, vecs[i].eAlert,
                        vecs[i].eGate, vecs[i].eOcc, vecs[i].eFull);
        end

        // Three wrong codes lock the entry for 200 cycles; a right code in between is ignored.
        applyStimulus(0, 1, 0, 0, PW_BAD, 0);
        checkOutput("lkWait", 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, PW_BAD, 1);
        checkOutput("wrong1", 1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, PW_BAD, 1);
        checkOutput("wrong2", 1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, PW_BAD, 1);
        checkOutput("lockEnter", 0, 0, 1, 0, 0, 0);
        bad = 0;
        for (int i = 1; i < 200; i++) begin
            applyStimulus(0, 0, 0, 0, PW_OK, (i == 50));
            if (!(led_alert === 1'b1 && led_wait === 1'b0 && led_available === 1'b0)) bad++;
        end
        checkCount("lockHeld", bad);
        applyStimulus(0, 0, 0, 0, PW_BAD, 0);
        checkOutput("lockExit", 0, 0, 0, 0, 0, 0);

        // Password timeout with no strobe at all.
        applyStimulus(0, 1, 0, 0, PW_BAD, 0);
        checkOutput("toWait", 1, 0, 0, 0, 0, 0);
        bad = 0;
        for (int i = 1; i < 100; i++) begin
            applyStimulus(0, 0, 0, 0, PW_BAD, 0);
            if (led_wait !== 1'b1) bad++;
        end
        checkCount("toHeld", bad);
        applyStimulus(0, 0, 0, 0, PW_BAD, 0);
        checkOutput("toExpire", 0, 0, 0, 0, 0, 0);

        // A wrong strobe restarts the timeout window.
        applyStimulus(0, 1, 0, 0, PW_BAD, 0);
        for (int i = 0; i < 50; i++) applyStimulus(0, 0, 0, 0, PW_BAD, 0);
        applyStimulus(0, 0, 0, 0, PW_BAD, 1);
        checkOutput("toWrong", 1, 0, 1, 0, 0, 0);
        bad = 0;
        for (int i = 1; i < 100; i++) begin
            applyStimulus(0, 0, 0, 0, PW_BAD, 0);
            if (!(led_wait === 1'b1 && led_alert === 1'b1)) bad++;
        end
        checkCount("toWrongHeld", bad);
        applyStimulus(0, 0, 0, 0, PW_BAD, 0);
        checkOutput("toWrongExpire", 0, 0, 0, 0, 0, 0);

        // The timeout cleared the try counter, so two more misses do not lock out.
        applyStimulus(0, 1, 0, 0, PW_BAD, 0);
        applyStimulus(0, 0, 0, 0, PW_BAD, 1);
        applyStimulus(0, 0, 0, 0, PW_BAD, 1);
        checkOutput("triesCleared", 1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, PW_OK, 1);
        checkOutput("retryRight", 0, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, PW_BAD, 0);
        checkOutput("retryPark", 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, PW_BAD, 0);

        // Fill the lot, then probe the full and overflow behaviour.
        applyStimulus(1, 0, 0, 0, PW_BAD, 0);
        checkOutput("rstFill", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) parkCar();
        checkOutput("fillFull", 0, 0, 0, 0, 8, 1);
        applyStimulus(0, 1, 0, 0, PW_BAD, 0);
        checkOutput("fullAlert", 0, 0, 1, 0, 8, 1);
        applyStimulus(0, 1, 0, 0, PW_OK, 1);
        checkOutput("fullHold", 0, 0, 1, 0, 8, 1);
        applyStimulus(0, 0, 0, 1, PW_BAD, 0);
        checkOutput("leaveFull", 0, 0, 0, 0, 7, 0);

        applyStimulus(0, 1, 0, 0, PW_BAD, 0);
        checkOutput("cdWait", 1, 0, 0, 0, 7, 0);
        applyStimulus(0, 1, 0, 0, PW_OK, 1);
        checkOutput("cdRight", 0, 1, 0, 1, 7, 0);
        applyStimulus(0, 1, 1, 0, PW_BAD, 0);
        checkOutput("cdTailgate", 0, 0, 1, 0, 8, 1);
        applyStimulus(0, 1, 1, 0, PW_OK, 1);
        checkOutput("cdStopRight", 0, 1, 0, 1, 8, 1);
        applyStimulus(0, 0, 0, 0, PW_BAD, 0);
        checkOutput("cdHold", 0, 1, 0, 1, 8, 1);
        applyStimulus(0, 0, 1, 0, PW_BAD, 0);
        checkOutput("capDrop", 0, 0, 1, 0, 8, 1);
        applyStimulus(0, 0, 0, 0, PW_BAD, 0);
        checkOutput("capIdle", 0, 0, 0, 0, 8, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
